// File: rtl/ws281x_tx_if.sv
// Pixel word handshake between a producer and the WS281X serializer.
interface ws281x_tx_if #(
  parameter int BITS = 24
);
  logic [BITS-1:0] Data;
  logic            Valid;
  logic            Ready;

  modport master (output Data, output Valid, input Ready);
  modport slave  (input Data, input Valid, output Ready);
endinterface

// File: rtl/ws281x_tx.sv
// WS281X serial transmitter: one-word holding register in front of a
// shifter that emits each bit as a high pulse (T0H or T1H clocks) inside a
// TBIT-clock period, followed by a TLATCH-clock low gap after the last word.
//
// state | meaning
// IDLE  | line low, waiting for a word in the holding register
// BIT   | shifting out a word; cnt counts down the clocks left in this bit
// LATCH | line low; cnt counts down the latch gap
module ws281x_tx #(
  parameter int BITS   = 24,
  parameter int T0H    = 20,
  parameter int T1H    = 40,
  parameter int TBIT   = 63,
  parameter int TLATCH = 2500
) (
  input  logic             Clock,
  input  logic             Reset,
  ws281x_tx_if.slave       bus,
  output logic             Dout,
  output logic             Busy,
  output logic [7:0]       PixCount
);

  if (!(T0H > 0 && T0H < T1H && T1H < TBIT && TLATCH >= 1)) begin : g_param_check
    $error("ws281x_tx: need 0 < T0H < T1H < TBIT and TLATCH >= 1");
  end

  // One counter serves both the bit period and the latch gap.
  localparam int CNT_MAX = (TBIT > TLATCH) ? TBIT : TLATCH;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int BW      = (BITS > 1) ? $clog2(BITS) : 1;

  localparam logic [CW-1:0] CNT_BIT   = CW'(TBIT - 1);
  localparam logic [CW-1:0] CNT_LATCH = CW'(TLATCH - 1);
  // The count runs TBIT-1 down to 0, so the first Tx clocks of a bit are
  // exactly those with cnt >= TBIT-Tx.
  localparam logic [CW-1:0] HI0_MIN   = CW'(TBIT - T0H);
  localparam logic [CW-1:0] HI1_MIN   = CW'(TBIT - T1H);
  localparam logic [BW-1:0] LAST_BIT  = BW'(BITS - 1);

  typedef enum logic [1:0] {IDLE, BIT, LATCH} state_t;

  state_t          state, state_n;
  logic            hold_full, hold_full_n;
  logic [BITS-1:0] hold_data, hold_data_n;
  logic [BITS-1:0] shift, shift_n;
  logic [BW-1:0]   idx, idx_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [7:0]      pix, pix_n;
  logic            dout_n;
  logic            accept;

  assign bus.Ready = ~hold_full;
  assign accept    = bus.Valid & ~hold_full;
  assign Busy      = (state != IDLE);
  assign PixCount  = pix;

  // Register all state; Dout is registered from the next-state decode.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      hold_data <= '0;
      shift     <= '0;
      idx       <= '0;
      cnt       <= '0;
      pix       <= '0;
      Dout      <= 1'b0;
    end else begin
      state     <= state_n;
      hold_full <= hold_full_n;
      hold_data <= hold_data_n;
      shift     <= shift_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      pix       <= pix_n;
      Dout      <= dout_n;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_n     = state;
    hold_full_n = hold_full;
    hold_data_n = hold_data;
    shift_n     = shift;
    idx_n       = idx;
    cnt_n       = cnt;
    pix_n       = pix;

    case (state)
      IDLE: begin
        if (hold_full) begin
          shift_n     = hold_data;
          idx_n       = '0;
          cnt_n       = CNT_BIT;
          hold_full_n = 1'b0;
          state_n     = BIT;
        end
      end
      BIT: begin
        if (cnt == '0) begin
          if (idx == LAST_BIT) begin
            pix_n = pix + 8'd1;
            if (hold_full) begin
              shift_n     = hold_data;
              idx_n       = '0;
              cnt_n       = CNT_BIT;
              hold_full_n = 1'b0;
            end else begin
              cnt_n   = CNT_LATCH;
              state_n = LATCH;
            end
          end else begin
            shift_n = shift << 1;
            idx_n   = idx + 1'b1;
            cnt_n   = CNT_BIT;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      LATCH: begin
        if (cnt == '0) begin
          pix_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Applied after the transfer so a same-edge accept leaves holding full.
    if (accept) begin
      hold_full_n = 1'b1;
      hold_data_n = bus.Data;
    end

    dout_n = (state_n == BIT) &&
             (cnt_n >= (shift_n[BITS-1] ? HI1_MIN : HI0_MIN));
  end

endmodule

// File: doc/ws281x_tx.md
WS281X_TX -- requirements
Module: ws281x_tx

Interface
- REQ-001 SHALL have parameter BITS, default 24, meaning bits per pixel word, sent MSB first.
- REQ-002 SHALL have parameter T0H, default 20, meaning high-time clocks for a 0 bit.
- REQ-003 SHALL have parameter T1H, default 40, meaning high-time clocks for a 1 bit.
- REQ-004 SHALL have parameter TBIT, default 63, meaning total clocks per bit (1.26 us at 50 MHz).
- REQ-005 SHALL have parameter TLATCH, default 2500, meaning low-time clocks for the latch/reset gap (50 us at 50 MHz).
- REQ-006 SHALL have port Clock, input, 1 bit, meaning the single clock; all state changes on its rising edge.
- REQ-007 SHALL have port Reset, input, 1 bit, meaning a synchronous, active-high reset.
- REQ-008 SHALL have port Data, input, BITS bits, meaning the pixel word offered.
- REQ-009 SHALL have port Valid, input, 1 bit, meaning Data is offered.
- REQ-010 SHALL have port Ready, output, 1 bit, meaning the holding register is empty.
- REQ-011 SHALL have port Dout, output, 1 bit, meaning the serial WS281X waveform, registered and glitch-free.
- REQ-012 SHALL have port Busy, output, 1 bit, meaning the state is not IDLE.
- REQ-013 SHALL have port PixCount, output, 8 bits, meaning words shifted out since the last latch completed.

Function
- REQ-014 SHALL reject, at elaboration, parameter sets violating 0<T0H<T1H<TBIT or TLATCH>=1; internal counter widths SHALL be derived from TBIT and TLATCH.
- REQ-015 SHALL accept a word on any rising edge where Valid and Ready are both 1, capturing Data into a one-word holding register; Ready SHALL equal not(holding full).
- REQ-016 SHALL implement states IDLE, BIT and LATCH only.
- REQ-017 IDLE: Dout=0; when holding is full, on the next edge SHALL move the word to the shifter, set bit index 0 and cycle count 0, empty holding, and enter BIT.
- REQ-018 BIT: Dout SHALL be 1 for the first T1H cycles of the bit if the shifter MSB is 1, else for the first T0H cycles, then 0 for the rest of TBIT.
- REQ-019 BIT: at cycle TBIT-1 of a bit that is not the last, SHALL shift left one position and restart the cycle count.
- REQ-020 BIT: at cycle TBIT-1 of bit BITS-1, SHALL increment PixCount (mod 256, wrapping 255->0).
- REQ-021 In the case of REQ-020, if holding is full on that same edge, SHALL load it with zero idle cycles between bits, stay in BIT, and empty holding; otherwise SHALL enter LATCH with cycle count 0.
- REQ-022 LATCH: Dout=0 for exactly TLATCH cycles; on the last cycle SHALL clear PixCount and go to IDLE.
- REQ-023 Words arriving during LATCH SHALL wait in holding and SHALL NOT shorten the latch.
- REQ-024 SHALL give one cycle of latency: a word accepted at edge k into an empty, idle block makes Dout rise after edge k+1.
- REQ-025 A simultaneous accept and holding-to-shifter transfer on one edge SHALL leave holding full with the new word; no word SHALL be lost or duplicated.
- REQ-026 Data and Valid SHALL be ignored while Ready=0.

Reset
- REQ-027 Reset=1 at a rising edge SHALL force IDLE, Dout=0, Busy=0, Ready=1 and PixCount=0, clear holding, shifter and counters, and abort any word mid-bit or mid-latch.
- REQ-028 Reset SHALL take priority over a simultaneous Valid; the word offered on that edge SHALL be dropped.
- REQ-029 Outputs SHALL be undefined only before the first reset edge.

Verification
- REQ-030 Single word 0xA50000: 24 bits SHALL appear with high times 40,20,40,20,20,40,20,40 followed by sixteen of 20, each in a 63-cycle period, then 2500 low cycles, then Busy=0 and PixCount=0.
- REQ-031 Back-to-back 0xFFFFFF then 0x000000 with Valid held: exactly 48 bit periods with no gap, then latch, and PixCount SHALL read 1 then 2 before clearing.
- REQ-032 Valid held continuously: Ready SHALL drop after each accept and rise once per 24x63 cycles; 300 words SHALL give PixCount wrapping 255->0 at word 256.
- REQ-033 Reset asserted at bit 10 cycle 5: Dout=0 after that edge, and a new word 0x800000 SHALL then give a first high time of exactly 40.
- REQ-034 Word offered at latch cycle 100: Dout SHALL stay 0 for the full 2500 cycles, and the word SHALL start on the edge after IDLE is re-entered.
